lcd_cmd_seq: RTL and testbench

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

---
 rtl/lcd_cmd_seq.sv | 90 +++++++++
 tb/tb_lcd_cmd_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: walks a command script ROM and hands each entry to an LCD controller
// over a busy/strobe handshake, with an ack timeout and completion pulse.
module lcd_cmd_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] CROM_Q,
    output logic       CROM_rd,
    output logic [4:0] CROM_A,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic       seq_busy,
    output logic       seq_done,
    output logic       seq_err,
    output logic [5:0] cmd_cnt
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT_ACK, WAIT_REL, WAIT_DONE, ERR} state_t;
    state_t     r_state, w_next;
    logic       r_last;
    logic [2:0] r_ack_age;
    logic       w_go, w_ack, w_final;
    logic       w_crom_rd, w_cmd_valid, w_seq_busy, w_seq_done, w_seq_err;

    assign w_go    = start && (r_state == IDLE || r_state == ERR);
    // busy seen in the strobe cycle itself predates the strobe, so it is not an ack
    assign w_ack   = lcd_busy && r_ack_age != 3'd0;
    assign w_final = r_last || CROM_A == 5'd31;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, ERR: if (start) w_next = FETCH;
            FETCH:     w_next = LATCH;
            LATCH:     w_next = ISSUE;
            ISSUE:     if (!lcd_busy) w_next = WAIT_ACK;
            WAIT_ACK:  if (w_ack) w_next = WAIT_REL; else if (r_ack_age == 3'd4) w_next = ERR;
            WAIT_REL:  if (!lcd_busy) w_next = !w_final ? FETCH : lcd_done ? IDLE : WAIT_DONE;
            WAIT_DONE: if (lcd_done) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // outputs are decoded from the upcoming state so they register in step with it
    always_comb begin
        w_crom_rd   = w_next == FETCH;
        w_cmd_valid = r_state == ISSUE && !lcd_busy;
        w_seq_busy  = w_next != IDLE && w_next != ERR;
        w_seq_done  = w_next == IDLE && (r_state == WAIT_DONE || r_state == WAIT_REL);
        w_seq_err   = w_next == ERR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            CROM_rd   <= 1'b0;
            CROM_A    <= 5'd0;
            cmd       <= 4'd0;
            cmd_valid <= 1'b0;
            seq_busy  <= 1'b0;
            seq_done  <= 1'b0;
            seq_err   <= 1'b0;
            cmd_cnt   <= 6'd0;
            r_last    <= 1'b0;
            r_ack_age <= 3'd0;
        end else begin
            CROM_rd   <= w_crom_rd;
            cmd_valid <= w_cmd_valid;
            seq_busy  <= w_seq_busy;
            seq_done  <= w_seq_done;
            seq_err   <= w_seq_err;
            r_ack_age <= r_state == WAIT_ACK ? r_ack_age + 3'd1 : 3'd0;
            if (r_state == LATCH) begin
                cmd    <= CROM_Q[3:0];
                r_last <= CROM_Q[4];
            end
            if (w_go) begin
                CROM_A  <= 5'd0;
                cmd_cnt <= 6'd0;
            end else begin
                if (r_state == WAIT_REL && w_next == FETCH) CROM_A <= CROM_A + 5'd1;
                if (r_state == WAIT_ACK && w_ack && cmd_cnt != 6'd63) cmd_cnt <= cmd_cnt + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_lcd_cmd_seq.sv
// tb_lcd_cmd_seq: randomized LCD responder and script ROM checked every cycle against
// an event-timestamp model of the sequencer, plus directed scenarios with literal expectations.
module tb_lcd_cmd_seq;
    logic       clk = 0, reset = 1, start = 0, lcd_busy = 0, lcd_done = 0;
    logic [4:0] CROM_Q, CROM_A;
    logic       CROM_rd, cmd_valid, seq_busy, seq_done, seq_err;
    logic [3:0] cmd;
    logic [5:0] cmd_cnt;
    logic [4:0] rom [32];

    int n_tests = 0, n_fail = 0, t = 0;
    int m_run, m_k, m_cnt, m_fetch, m_s;
    bit m_issued, m_acked, m_wdone;
    logic [3:0] m_cmd;
    bit l_resp;
    int l_a, l_d, l_l, l_dd, l_burst, l_done_at = -100, l_rel;
    int fix_d = -1, fix_l = -1, fix_dd = -1, rst_cycles = 3;
    bit bursts_en, spur_en, rnd_start, hold20, start_req;
    int q_cmd[$], q_addr[$];
    int n_done, t_ff, t_s1, t_err, t_done;
    int exp_b[3] = '{3, 5, 0};

    lcd_cmd_seq dut (
        .clk(clk), .reset(reset), .start(start), .CROM_Q(CROM_Q), .CROM_rd(CROM_rd),
        .CROM_A(CROM_A), .lcd_busy(lcd_busy), .lcd_done(lcd_done), .cmd(cmd),
        .cmd_valid(cmd_valid), .seq_busy(seq_busy), .seq_done(seq_done),
        .seq_err(seq_err), .cmd_cnt(cmd_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (CROM_rd) CROM_Q <= rom[CROM_A];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, t);
        end
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_crom_rd"}, CROM_rd, 0);
        chk({nm, "_crom_a"}, CROM_A, 0);
        chk({nm, "_cmd"}, cmd, 0);
        chk({nm, "_cmd_valid"}, cmd_valid, 0);
        chk({nm, "_seq_busy"}, seq_busy, 0);
        chk({nm, "_seq_done"}, seq_done, 0);
        chk({nm, "_seq_err"}, seq_err, 0);
        chk({nm, "_cmd_cnt"}, cmd_cnt, 0);
    endtask

    task automatic m_clear();
        m_run = 0; m_k = 0; m_cnt = 0; m_fetch = -100; m_s = -100;
        m_issued = 0; m_acked = 0; m_wdone = 0; m_cmd = 0;
    endtask

    task automatic rec_clear();
        q_cmd.delete(); q_addr.delete();
        n_done = 0; t_ff = -1; t_s1 = -1; t_err = -1; t_done = -1;
    endtask

    task automatic cyc();
        logic pb, pd, ps, b, dn;
        bit e_rd, e_valid, e_done, acc;
        @(posedge clk); #1; t++;
        pb = lcd_busy; pd = lcd_done; ps = start;
        if (reset) begin
            chk_zero("rst");
            m_clear();
        end else begin
            e_valid = 0; e_done = 0;
            acc = ps && m_run != 1;
            if (m_run == 1) begin
                if (!m_issued) begin
                    if (t - 1 >= m_fetch + 2 && !pb) begin m_issued = 1; m_s = t; e_valid = 1; end
                end else if (!m_acked) begin
                    if (pb && t - 1 >= m_s + 1) begin m_acked = 1; if (m_cnt < 63) m_cnt++; end
                    else if (t - 1 == m_s + 4) m_run = 2;
                end else if (!m_wdone) begin
                    if (!pb) begin
                        if (rom[m_k][4] || m_k == 31) begin
                            if (pd) begin m_run = 0; e_done = 1; end else m_wdone = 1;
                        end else begin
                            m_k++; m_fetch = t; m_issued = 0; m_acked = 0;
                        end
                    end
                end else if (pd) begin m_run = 0; e_done = 1; end
            end
            if (acc) begin
                m_run = 1; m_k = 0; m_cnt = 0; m_fetch = t; m_issued = 0; m_acked = 0; m_wdone = 0;
            end
            if (m_run == 1 && t == m_fetch + 2) m_cmd = rom[m_k][3:0];
            e_rd = m_run == 1 && t == m_fetch;
            chk("crom_rd", CROM_rd, e_rd);
            if (e_rd) chk("crom_a", CROM_A, m_k);
            chk("cmd_valid", cmd_valid, e_valid);
            chk("cmd", cmd, m_cmd);
            chk("seq_busy", seq_busy, m_run == 1);
            chk("seq_err", seq_err, m_run == 2);
            chk("seq_done", seq_done, e_done);
            chk("cmd_cnt", cmd_cnt, m_cnt);
            if (CROM_rd) begin if (q_addr.size() == 0) t_ff = t; q_addr.push_back(CROM_A); end
            if (cmd_valid) begin if (q_cmd.size() == 0) t_s1 = t; q_cmd.push_back(cmd); end
            if (seq_done) begin n_done++; t_done = t; end
            if (seq_err && t_err < 0) t_err = t;
        end
        if (rst_cycles > 0) rst_cycles--;
        reset = rst_cycles > 0;
        start = start_req || (rnd_start && $urandom_range(29) == 0);
        start_req = 0;
        b = 0; dn = 0;
        if (reset) begin
            l_resp = 0; l_burst = 0; l_done_at = -100;
        end else begin
            if (cmd_valid) begin
                l_resp = 1; l_a = 0; l_burst = 0;
                l_d  = fix_d >= 0 ? fix_d : ($urandom_range(11) == 0 ? 0 : int'($urandom_range(4, 1)));
                l_l  = fix_l >= 0 ? fix_l : int'($urandom_range(5, 1));
                l_dd = fix_dd >= 0 ? fix_dd : int'($urandom_range(3, 0));
            end else if (l_resp) l_a++;
            if (l_resp) begin
                b = l_d != 0 && l_a >= l_d && l_a < l_d + l_l;
                if (l_d != 0 && l_a == l_d + l_l) begin l_resp = 0; l_done_at = t + l_dd; l_rel = t; end
                if (l_d == 0 && l_a == 4) l_resp = 0;
            end else begin
                if (hold20 && CROM_rd) begin l_burst = 20; hold20 = 0; end
                else if (bursts_en && l_burst == 0 && $urandom_range(4) == 0) l_burst = $urandom_range(6, 1);
                if (l_burst > 0) begin b = 1; l_burst--; end
                dn = spur_en && $urandom_range(39) == 0;
            end
            dn = dn || t == l_done_at;
        end
        lcd_busy = b;
        lcd_done = dn;
    endtask

    task automatic finish_run(int maxc);
        for (int i = 0; i < maxc && m_run == 1; i++) cyc();
        chk("run_bound", m_run == 1, 0);
    endtask

    task automatic go(int maxc);
        start_req = 1;
        cyc();
        cyc();
        finish_run(maxc);
    endtask

    task automatic idle(int n);
        repeat (n) cyc();
    endtask

    task automatic rom_b();
        for (int i = 0; i < 32; i++) rom[i] = 5'h00;
        rom[0] = 5'h03; rom[1] = 5'h05; rom[2] = 5'h10;
    endtask

    initial begin
        m_clear();
        rec_clear();
        rom_b();
        idle(4);
        chk_zero("post_rst");

        fix_d = 1; fix_l = 3; fix_dd = 2;
        rec_clear();
        go(200);
        idle(6);
        chk("b_ncmd", q_cmd.size(), 3);
        for (int i = 0; i < 3 && i < q_cmd.size(); i++) chk("b_cmd", q_cmd[i], exp_b[i]);
        for (int i = 0; i < q_addr.size(); i++) chk("b_addr", q_addr[i], i);
        chk("b_nfetch", q_addr.size(), 3);
        chk("b_cnt", cmd_cnt, 3);
        chk("b_ndone", n_done, 1);
        chk("b_done_lag", t_done - l_rel, 3);

        rec_clear();
        hold20 = 1;
        go(300);
        idle(3);
        chk("c_gap", t_s1 - t_ff, 21);
        chk("c_ncmd", q_cmd.size(), 3);

        rec_clear();
        fix_d = 0;
        go(100);
        chk("d_err_lag", t_err - t_s1, 5);
        chk("d_err", seq_err, 1);
        chk("d_busy", seq_busy, 0);
        chk("d_ncmd", q_cmd.size(), 1);
        idle(4);
        chk("d_err_hold", seq_err, 1);
        fix_d = 1;
        rec_clear();
        go(200);
        idle(2);
        chk("d_err_clr", seq_err, 0);
        chk("d_ndone", n_done, 1);

        for (int i = 0; i < 32; i++) rom[i] = {1'b0, 4'(i * 7 + 3)};
        fix_l = 1; fix_dd = 1;
        rec_clear();
        go(2000);
        idle(3);
        chk("e_ncmd", q_cmd.size(), 32);
        chk("e_nfetch", q_addr.size(), 32);
        if (q_addr.size() > 0) chk("e_addr_last", q_addr[$], 31);
        chk("e_cnt", cmd_cnt, 32);
        chk("e_ndone", n_done, 1);

        rom_b();
        fix_l = 3; fix_dd = 2;
        start_req = 1;
        cyc();
        for (int i = 0; i < 100 && !(m_run == 1 && m_k == 1 && m_acked); i++) cyc();
        chk("f_reach_rel1", m_run == 1 && m_k == 1 && m_acked, 1);
        @(negedge clk);
        reset = 1;
        #1;
        chk_zero("f_async");
        rst_cycles = 3;
        start_req = 1;
        idle(8);
        chk("f_idle", seq_busy, 0);
        rec_clear();
        go(200);
        idle(3);
        chk("f_ncmd", q_cmd.size(), 3);
        if (q_addr.size() > 0) chk("f_addr0", q_addr[0], 0);
        if (q_cmd.size() > 0) chk("f_cmd0", q_cmd[0], 3);

        fix_d = 2; fix_l = 2; fix_dd = 0;
        rec_clear();
        go(200);
        idle(10);
        chk("g_done_lag", t_done - l_rel, 1);
        chk("g_nfetch", q_addr.size(), 3);
        chk("g_ndone", n_done, 1);

        fix_d = -1; fix_l = -1; fix_dd = -1;
        bursts_en = 1; spur_en = 1;
        repeat (40) begin
            rnd_start = 0;
            idle(2);
            finish_run(3000);
            for (int i = 0; i < 32; i++) begin
                rom[i] = 5'($urandom);
                rom[i][4] = $urandom_range(5) == 0;
            end
            rnd_start = 1;
            go(3000);
            idle($urandom_range(10, 1));
        end
        rnd_start = 0;
        idle(2);
        finish_run(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
